four12_unpack: RTL and testbench
================================

# four12_unpack

Serializer and overflow handler for the packed result of a FOUR12 SIMD DSP48E2 adder. Accepts one 48-bit packed word plus its 4-bit lane carry vector under a valid/ready handshake, and emits the four 12-bit lanes one per cycle on a valid/ready stream. Optionally saturates each lane from its carry bit. Sits between the FOUR12 adder's P/CARRYOUT outputs and downstream per-sample logic.

## Interface
- `LANE_ORDER`, default "LSB_FIRST": lane emission order. "LSB_FIRST" emits 0,1,2,3; "MSB_FIRST" emits 3,2,1,0.
- `CARRY_POL`, default 1: carry polarity that flags overflow. 1 means carry set = overflow (add mode, clamp high). 0 means carry clear = underflow (subtract mode, clamp low).
- `clk_i` in, 1: clock.
- `rst_i` in, 1: reset. Synchronous, active-high.
- `in_data_i` in, 48: packed word. Lane k is bits [12k+11:12k].
- `in_carry_i` in, 4: lane carries. Bit k belongs to lane k.
- `in_valid_i` in, 1: input word valid.
- `in_ready_o` out, 1: block can accept a word.
- `out_data_o` out, 12: lane value, raw or saturated.
- `out_lane_o` out, 2: physical lane index k of the current output.
- `out_ovf_o` out, 1: lane k was flagged by its carry, per `CARRY_POL`.
- `out_last_o` out, 1: final lane of the word.
- `out_valid_o` out, 1: output valid.
- `out_ready_i` in, 1: downstream accepts.

## Operation
- Two word registers:
  - `cur` is the word being serialized. It holds data, carry, a valid flag, and a 2-bit step counter.
  - `nxt` is the pending word. It holds data, carry, and a valid flag.
- Input handshake:
  - `in_ready_o = !nxt_valid && !rst_i`.
  - A word is accepted when `in_valid_i && in_ready_o`.
- Routing of an accepted word:
  - It loads `cur` if `cur` is empty, or if `cur` is completing its last lane this cycle and `nxt` is empty.
  - Otherwise it loads `nxt`.
- Output advance:
  - Output fires on `out_valid_o && out_ready_i`.
  - On fire with step < 3: step increments.
  - On fire with step == 3: step returns to 0. `cur` takes `nxt` if `nxt` is valid (and `nxt` clears). Otherwise it takes the same-cycle accepted input, else `cur` goes empty.
- Output fields:
  - `out_valid_o = cur_valid`.
  - Lane index = step for LSB_FIRST, 3−step for MSB_FIRST.
  - `out_last_o = (step == 3)`.
  - `out_ovf_o = (carry[k] == CARRY_POL)`.
- Output holds stable while `out_valid_o && !out_ready_i`. No field changes.
- No state machine beyond the step counter. The block has states EMPTY (`cur` empty), BUSY (`cur` valid only) and FULL (both valid).
- Simultaneous accept and last-lane fire in FULL cannot occur, because `in_ready_o` is 0 in FULL.
- Reset:
  - Clears both valid flags and the step counter.
  - Word data registers are don't-care.
  - All outputs read 0 during and after reset until a word is loaded. The exception is `out_data_o`/`out_lane_o`, which may show stale data while `out_valid_o` is 0.
  - Reset mid-word discards both words with no further output.

## Timing
- Latency: a word accepted at edge N presents lane 0 (or lane 3 for MSB_FIRST) with `out_valid_o` = 1 after edge N.
- Throughput: one lane per cycle with `out_ready_i` held high.
  - One word per 4 cycles sustained, with no bubbles between words.
  - The next word's first lane follows the previous `out_last_o` fire on the next cycle.
- `in_ready_o` depends only on registered state plus `rst_i`. There is no combinational path from `out_ready_i`.
- Two words of buffering: upstream may issue 2 words back-to-back from EMPTY. A third word stalls until the first word's last lane fires.

## Configuration
- Macro `FOUR12_UNPACK_SAT_EN`.
- Defined: a lane with `out_ovf_o` = 1 outputs 12'hFFF when `CARRY_POL` = 1, or 12'h000 when `CARRY_POL` = 0. Unflagged lanes pass raw.
- Undefined: `out_data_o` is always the raw lane bits. `out_ovf_o` is still reported. There is no saturation logic.

## Test plan
- Reset then idle:
  - Required: `out_valid_o` = 0 and `in_ready_o` = 0 during reset.
  - Required: `in_ready_o` = 1 the cycle after reset.
- Single word, LSB_FIRST, `out_ready_i` = 1. Stimulus: data 0xABC_123_456_789, carry 0.
  - Required outputs, one per cycle with lanes 0..3: 0x789, 0x456, 0x123, 0xABC.
  - Required: `out_last_o` only on 0xABC.
- Saturation, `FOUR12_UNPACK_SAT_EN` defined, `CARRY_POL` = 1. Stimulus: data 0x001_002_003_004, carry 4'b0101.
  - Required outputs: 0xFFF(ovf), 0x003, 0xFFF(ovf), 0x001.
  - Without the macro: 0x004(ovf), 0x003, 0x002(ovf), 0x001.
- Backpressure: 3 words offered back-to-back with `out_ready_i` = 0.
  - Required: words 1 and 2 are accepted, then `in_ready_o` = 0.
  - Required: the output holds lane 0 of word 1 unchanged.
  - Required: on release, 12 lanes stream in order and word 3 is accepted after word 1's last lane fires.
- MSB_FIRST, `CARRY_POL` = 0. Stimulus: carry 4'b1110.
  - Required: lanes emitted 3,2,1,0.
  - Required: `out_ovf_o` only on lane 0, clamped to 0x000 when the macro is defined.
- Reset asserted during the lane 2 output, with `nxt` full.
  - Required: the next cycle `out_valid_o` = 0.
  - Required: no remaining lanes are emitted and `in_ready_o` returns to 1 after reset.

Source files
------------

// File: rtl/four12_unpack_if.sv
// Handshake bundle for four12_unpack: a 48-bit packed FOUR12 word with lane carries in,
// and a 12-bit lane stream out.
interface four12_unpack_if;
    logic [47:0] in_data_i;
    logic [3:0]  in_carry_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [11:0] out_data_o;
    logic [1:0]  out_lane_o;
    logic        out_ovf_o;
    logic        out_last_o;
    logic        out_valid_o;
    logic        out_ready_i;

    modport slave (
        input  in_data_i, in_carry_i, in_valid_i,
        output in_ready_o,
        output out_data_o, out_lane_o, out_ovf_o, out_last_o, out_valid_o,
        input  out_ready_i
    );

    modport master (
        output in_data_i, in_carry_i, in_valid_i,
        input  in_ready_o,
        input  out_data_o, out_lane_o, out_ovf_o, out_last_o, out_valid_o,
        output out_ready_i
    );
endinterface

// File: rtl/four12_unpack.sv
// Serializes a FOUR12 packed adder result into four 12-bit lanes with carry-based overflow flags.
// Optional macro FOUR12_UNPACK_SAT_EN clamps flagged lanes (0xFFF for CARRY_POL=1, 0x000 for 0).
module four12_unpack #(
    parameter string LANE_ORDER = "LSB_FIRST",
    parameter bit    CARRY_POL  = 1'b1
) (
    input  logic           clk_i,
    input  logic           rst_i,
    four12_unpack_if.slave bus
);
    localparam bit MSB_FIRST_C = (LANE_ORDER == "MSB_FIRST");

    logic [47:0] r_cur_data;
    logic [3:0]  r_cur_carry;
    logic        r_cur_valid;
    logic [1:0]  r_step;
    logic [47:0] r_nxt_data;
    logic [3:0]  r_nxt_carry;
    logic        r_nxt_valid;

    logic        w_in_ready;
    logic        w_accept;
    logic        w_fire;
    logic        w_last_fire;
    logic        w_to_cur;
    logic [1:0]  w_lane;
    logic [11:0] w_raw;
    logic        w_ovf;
    logic [11:0] w_data;

    function automatic logic [11:0] lane_slice(input logic [47:0] word, input logic [1:0] k);
        logic [11:0] v;
        case (k)
            2'd0:    v = word[11:0];
            2'd1:    v = word[23:12];
            2'd2:    v = word[35:24];
            2'd3:    v = word[47:36];
            default: v = 12'h000;
        endcase
        return v;
    endfunction

    // Handshake decode and output lane selection
    always_comb begin
        w_in_ready  = !r_nxt_valid && !rst_i;
        w_accept    = bus.in_valid_i && w_in_ready;
        w_fire      = r_cur_valid && bus.out_ready_i;
        w_last_fire = w_fire && (r_step == 2'd3);
        // an accepted word can only arrive with nxt empty, so cur takes it whenever cur frees up
        w_to_cur    = !r_cur_valid || w_last_fire;
        if (MSB_FIRST_C) begin
            w_lane = 2'd3 - r_step;
        end else begin
            w_lane = r_step;
        end
        w_raw = lane_slice(r_cur_data, w_lane);
        w_ovf = r_cur_valid && (r_cur_carry[w_lane] == CARRY_POL);
`ifdef FOUR12_UNPACK_SAT_EN
        if (w_ovf) begin
            w_data = CARRY_POL ? 12'hFFF : 12'h000;
        end else begin
            w_data = w_raw;
        end
`else
        w_data = w_raw;
`endif
    end

    // Occupancy flags and lane step counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cur_valid <= 1'b0;
            r_nxt_valid <= 1'b0;
            r_step      <= 2'd0;
        end else begin
            if (w_last_fire) begin
                r_step <= 2'd0;
                if (r_nxt_valid) begin
                    r_cur_valid <= 1'b1;
                    r_nxt_valid <= 1'b0;
                end else begin
                    r_cur_valid <= w_accept;
                end
            end else begin
                if (w_fire) begin
                    r_step <= r_step + 2'd1;
                end
                if (!r_cur_valid && w_accept) begin
                    r_cur_valid <= 1'b1;
                end
            end
            if (w_accept && !w_to_cur) begin
                r_nxt_valid <= 1'b1;
            end
        end
    end

    // Word payload registers; contents are don't-care while their valid flag is low
    always_ff @(posedge clk_i) begin
        if (w_last_fire && r_nxt_valid) begin
            r_cur_data  <= r_nxt_data;
            r_cur_carry <= r_nxt_carry;
        end else if (w_accept && w_to_cur) begin
            r_cur_data  <= bus.in_data_i;
            r_cur_carry <= bus.in_carry_i;
        end
        if (w_accept && !w_to_cur) begin
            r_nxt_data  <= bus.in_data_i;
            r_nxt_carry <= bus.in_carry_i;
        end
    end

    assign bus.in_ready_o  = w_in_ready;
    assign bus.out_valid_o = r_cur_valid;
    assign bus.out_data_o  = w_data;
    assign bus.out_lane_o  = w_lane;
    assign bus.out_ovf_o   = w_ovf;
    assign bus.out_last_o  = r_cur_valid && (r_step == 2'd3);
endmodule

// File: tb/tb_four12_unpack.sv
// Self-checking bench for four12_unpack: directed scenarios plus random traffic against a lane-queue model.
// Two instances share stimulus: LSB_FIRST/CARRY_POL=1 and MSB_FIRST/CARRY_POL=0.
module tb_four12_unpack;
    typedef struct packed {
        logic [11:0] data;
        logic [1:0]  lane;
        logic        ovf;
        logic        last;
    } lane_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [47:0] d_data;
    logic [3:0]  d_carry;
    logic        d_valid;
    logic        d_ready;

    int checks   = 0;
    int failures = 0;
    lane_t qa[$];
    lane_t qb[$];

    four12_unpack_if ifa();
    four12_unpack_if ifb();

    assign ifa.in_data_i   = d_data;
    assign ifa.in_carry_i  = d_carry;
    assign ifa.in_valid_i  = d_valid;
    assign ifa.out_ready_i = d_ready;
    assign ifb.in_data_i   = d_data;
    assign ifb.in_carry_i  = d_carry;
    assign ifb.in_valid_i  = d_valid;
    assign ifb.out_ready_i = d_ready;

    four12_unpack #(.LANE_ORDER("LSB_FIRST"), .CARRY_POL(1'b1)) u_dut_lsb (
        .clk_i(clk_i), .rst_i(rst_i), .bus(ifa.slave));
    four12_unpack #(.LANE_ORDER("MSB_FIRST"), .CARRY_POL(1'b0)) u_dut_msb (
        .clk_i(clk_i), .rst_i(rst_i), .bus(ifb.slave));

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [47:0] got, input logic [47:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Expected lane i (emission order) of a word, from the lane/carry/saturation rules
    function automatic lane_t mk_lane(input bit msb, input bit pol, input logic [47:0] d,
                                      input logic [3:0] c, input int i);
        lane_t e;
        int    k;
        k      = msb ? 3 - i : i;
        e.data = d[12*k +: 12];
        e.lane = k[1:0];
        e.ovf  = (c[k] == pol);
`ifdef FOUR12_UNPACK_SAT_EN
        if (e.ovf) e.data = pol ? 12'hFFF : 12'h000;
`endif
        e.last = (i == 3);
        return e;
    endfunction

    task automatic check_port(input string tag, input logic vld, input logic [11:0] dat,
                              input logic [1:0] ln, input logic ov, input logic ls,
                              input bit has, input lane_t e);
        check_eq({tag, "_valid"}, {47'd0, vld}, {47'd0, has});
        if (has) begin
            check_eq({tag, "_data"}, {36'd0, dat}, {36'd0, e.data});
            check_eq({tag, "_lane"}, {46'd0, ln}, {46'd0, e.lane});
            check_eq({tag, "_ovf"},  {47'd0, ov}, {47'd0, e.ovf});
            check_eq({tag, "_last"}, {47'd0, ls}, {47'd0, e.last});
        end else begin
            check_eq({tag, "_idle_ovf"},  {47'd0, ov}, 48'd0);
            check_eq({tag, "_idle_last"}, {47'd0, ls}, 48'd0);
        end
    endtask

    // One cycle: compare against model, clock, then advance the model by the handshakes
    task automatic step();
        bit    exp_rdy;
        bit    acc;
        bit    fa;
        bit    fb;
        lane_t ea;
        lane_t eb;
        #1;
        exp_rdy = (((qa.size() + 3) / 4) < 2) && !rst_i;
        check_eq("ready_a", {47'd0, ifa.in_ready_o}, {47'd0, exp_rdy});
        check_eq("ready_b", {47'd0, ifb.in_ready_o}, {47'd0, exp_rdy});
        ea = (qa.size() > 0) ? qa[0] : '0;
        eb = (qb.size() > 0) ? qb[0] : '0;
        check_port("a", ifa.out_valid_o, ifa.out_data_o, ifa.out_lane_o, ifa.out_ovf_o,
                   ifa.out_last_o, qa.size() > 0, ea);
        check_port("b", ifb.out_valid_o, ifb.out_data_o, ifb.out_lane_o, ifb.out_ovf_o,
                   ifb.out_last_o, qb.size() > 0, eb);
        acc = d_valid && exp_rdy;
        fa  = (qa.size() > 0) && d_ready;
        fb  = (qb.size() > 0) && d_ready;
        @(posedge clk_i);
        if (rst_i) begin
            qa.delete();
            qb.delete();
        end else begin
            if (fa) void'(qa.pop_front());
            if (fb) void'(qb.pop_front());
            if (acc) begin
                for (int i = 0; i < 4; i++) begin
                    qa.push_back(mk_lane(1'b0, 1'b1, d_data, d_carry, i));
                    qb.push_back(mk_lane(1'b1, 1'b0, d_data, d_carry, i));
                end
            end
        end
        @(negedge clk_i);
    endtask

    logic [11:0] sw_exp [4];
    logic [11:0] sat_exp [4];
    logic [11:0] msb_exp [4];
    logic [3:0]  sat_ovf;
    logic [47:0] w1;
    logic [47:0] w2;
    logic [47:0] w3;
    logic [63:0] r64;
    int          k;

    initial begin
        sw_exp  = '{12'h789, 12'h456, 12'h123, 12'hABC};
`ifdef FOUR12_UNPACK_SAT_EN
        sat_exp = '{12'hFFF, 12'h003, 12'hFFF, 12'h001};
        msb_exp = '{12'h001, 12'h002, 12'h003, 12'h000};
`else
        sat_exp = '{12'h004, 12'h003, 12'h002, 12'h001};
        msb_exp = '{12'h001, 12'h002, 12'h003, 12'h004};
`endif
        sat_ovf = 4'b0101;
        rst_i = 1'b1; d_valid = 1'b0; d_ready = 1'b0; d_data = 48'd0; d_carry = 4'd0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        step();
        step();
        rst_i = 1'b0;
        #1 check_eq("post_reset_ready", {47'd0, ifa.in_ready_o}, 48'd1);
        step();

        // single word, LSB order
        d_ready = 1'b1; d_valid = 1'b1; d_data = 48'hABC123456789; d_carry = 4'b0000;
        step();
        d_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq("sw_data", {36'd0, ifa.out_data_o}, {36'd0, sw_exp[i]});
            check_eq("sw_last", {47'd0, ifa.out_last_o}, {47'd0, (i == 3)});
            step();
        end
        step();

        // saturation / overflow reporting
        d_valid = 1'b1; d_data = 48'h001002003004; d_carry = 4'b0101;
        step();
        d_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq("sat_data", {36'd0, ifa.out_data_o}, {36'd0, sat_exp[i]});
            check_eq("sat_ovf", {47'd0, ifa.out_ovf_o}, {47'd0, sat_ovf[i]});
            step();
        end
        step();

        // MSB order, underflow polarity
        d_valid = 1'b1; d_data = 48'h001002003004; d_carry = 4'b1110;
        step();
        d_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq("msb_lane", {46'd0, ifb.out_lane_o}, 48'(3 - i));
            check_eq("msb_ovf", {47'd0, ifb.out_ovf_o}, {47'd0, (i == 3)});
            check_eq("msb_data", {36'd0, ifb.out_data_o}, {36'd0, msb_exp[i]});
            step();
        end
        step();

        // backpressure: two words buffer, third stalls until word 1's last lane fires
        r64 = {$urandom(), $urandom()}; w1 = r64[47:0];
        r64 = {$urandom(), $urandom()}; w2 = r64[47:0];
        r64 = {$urandom(), $urandom()}; w3 = r64[47:0];
        d_ready = 1'b0; d_valid = 1'b1; d_carry = 4'b0011;
        d_data = w1; step();
        d_data = w2; step();
        d_data = w3;
        #1 check_eq("bp_full_ready", {47'd0, ifa.in_ready_o}, 48'd0);
        repeat (3) step();
        check_eq("bp_hold_data", {36'd0, ifa.out_data_o}, {36'd0, w1[11:0]});
        d_ready = 1'b1;
        k = 0;
        while (k < 20) begin
            #1;
            if (ifa.in_ready_o) break;
            step();
            k++;
        end
        check_eq("bp_w3_wait", 48'(k), 48'd4);
        step();
        d_valid = 1'b0;
        repeat (10) step();

        // reset while lane 2 is showing and nxt holds a word
        d_ready = 1'b0; d_valid = 1'b1;
        d_data = w1; step();
        d_data = w2; step();
        d_valid = 1'b0; d_ready = 1'b1;
        step();
        step();
        #1 check_eq("rst_mid_lane", {46'd0, ifa.out_lane_o}, 48'd2);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        #1 check_eq("rst_mid_valid", {47'd0, ifa.out_valid_o}, 48'd0);
        check_eq("rst_mid_ready", {47'd0, ifa.in_ready_o}, 48'd1);
        repeat (6) step();

        // random traffic
        for (int n = 0; n < 500; n++) begin
            rst_i   = ($urandom_range(0, 79) == 0);
            d_valid = ($urandom_range(0, 2) != 0);
            d_ready = ($urandom_range(0, 3) != 0);
            r64     = {$urandom(), $urandom()};
            d_data  = r64[47:0];
            d_carry = 4'($urandom_range(0, 15));
            step();
        end
        rst_i = 1'b0; d_valid = 1'b0; d_ready = 1'b1;
        repeat (12) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
